// File: rtl/btn_event_debouncer.sv
`default_nettype none
// ============================================================================
// btn_event_debouncer: N-channel synchroniser, debouncer and button event
// generator (press / release / click / long-press / auto-repeat).  Rev 1.0
// ============================================================================
module btn_event_debouncer #(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] click_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int c_REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);
  localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_accept;
    logic [c_DB_W-1:0]      r_cnt_db, w_cnt_db_nxt;
    logic                   r_level, w_level_nxt;
    state_t                 r_state, w_state_nxt;
    logic [c_HOLD_W-1:0]    r_hold_cnt, w_hold_nxt;
    logic [c_REP_W-1:0]     r_rep_cnt, w_rep_nxt;
    logic                   r_long_seen, w_long_seen_nxt;
    logic                   r_press, w_press;
    logic                   r_release, w_release;
    logic                   r_click, w_click;
    logic                   r_long, w_long;
    logic                   r_repeat, w_repeat;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
      w_accept        = (w_s != r_level) && (r_cnt_db == c_DB_LAST);
      w_cnt_db_nxt    = '0;
      if ((w_s != r_level) && !w_accept)
        w_cnt_db_nxt = r_cnt_db + c_DB_W'(1);
      w_level_nxt     = w_accept ? w_s : r_level;

      w_state_nxt     = r_state;
      w_hold_nxt      = r_hold_cnt;
      w_rep_nxt       = r_rep_cnt;
      w_long_seen_nxt = r_long_seen;
      w_press         = 1'b0;
      w_release       = 1'b0;
      w_click         = 1'b0;
      w_long          = 1'b0;
      w_repeat        = 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept && w_s) begin
            w_state_nxt     = S_PRESSED;
            w_press         = 1'b1;
            w_hold_nxt      = '0;
            w_rep_nxt       = '0;
            w_long_seen_nxt = 1'b0;
          end
        end
        S_PRESSED: begin
          // An accepted release outranks a long-press landing on the same edge
          if (w_accept && !w_s) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
            w_click     = !r_long_seen;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            w_state_nxt     = S_LONG;
            w_long          = 1'b1;
            w_long_seen_nxt = 1'b1;
            w_rep_nxt       = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
          end
        end
        S_LONG: begin
          if (w_accept && !w_s) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
            w_click     = !r_long_seen;
          end else if (!repeat_en[i]) begin
            w_rep_nxt = '0;
          end else if (r_rep_cnt == c_REP_LAST) begin
            w_rep_nxt = '0;
            w_repeat  = 1'b1;
          end else begin
            w_rep_nxt = r_rep_cnt + c_REP_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync      <= '0;
        r_cnt_db    <= '0;
        r_level     <= 1'b0;
        r_state     <= S_IDLE;
        r_hold_cnt  <= '0;
        r_rep_cnt   <= '0;
        r_long_seen <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_click     <= 1'b0;
        r_long      <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_sync      <= {r_sync[SYNC_STAGES-2:0], btn[i]};
        r_cnt_db    <= w_cnt_db_nxt;
        r_level     <= w_level_nxt;
        r_state     <= w_state_nxt;
        r_hold_cnt  <= w_hold_nxt;
        r_rep_cnt   <= w_rep_nxt;
        r_long_seen <= w_long_seen_nxt;
        r_press     <= w_press;
        r_release   <= w_release;
        r_click     <= w_click;
        r_long      <= w_long;
        r_repeat    <= w_repeat;
      end
    end

    assign level[i]         = r_level;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign click_pulse[i]   = r_click;
    assign long_pulse[i]    = r_long;
    assign repeat_pulse[i]  = r_repeat;
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_btn_event_debouncer: scoreboard bench with a window-based reference model.
// Rev 1.0
// ============================================================================
module tb_btn_event_debouncer;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int HL   = SYNC + DB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] level, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;

  btn_event_debouncer #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .repeat_en(repeat_en),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .click_pulse(click_pulse), .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // kind: 0 press, 1 release, 2 click, 3 long, 4 repeat
  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  int  hist [N][HL];
  bit  m_level [N];
  bit  m_long [N];
  int  m_press_at [N];
  int  m_run [N];

  int  seen_cnt [N][5];
  int  seen_first [N][5];
  int  seen_last [N][5];

  function automatic void push_ev(int c, int k);
    ev_t e;
    e.cyc = cyc; e.ch = c; e.kind = k;
    exp_q.push_back(e);
  endfunction

  // Reference model: a level flips when the DB synchronised samples leading
  // up to the edge all disagree with it; events follow from edge arithmetic.
  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (!reset) begin
        for (int k = 0; k < HL; k++) hist[c][k] = 0;
        m_level[c] = 0; m_long[c] = 0; m_run[c] = 0; m_press_at[c] = 0;
      end else begin
        bit acc;
        for (int k = 0; k < HL - 1; k++) hist[c][k] = hist[c][k+1];
        hist[c][HL-1] = int'(btn[c]);
        acc = 1'b1;
        for (int k = 0; k < DB; k++)
          if (hist[c][k] == int'(m_level[c])) acc = 1'b0;
        if (acc && !m_level[c]) begin
          push_ev(c, 0);
          m_level[c] = 1; m_long[c] = 0; m_run[c] = 0; m_press_at[c] = cyc;
        end else if (acc && m_level[c]) begin
          push_ev(c, 1);
          if (!m_long[c]) push_ev(c, 2);
          m_level[c] = 0; m_long[c] = 0;
        end else if (m_level[c] && !m_long[c]) begin
          if (cyc - m_press_at[c] == LONG) begin
            push_ev(c, 3);
            m_long[c] = 1; m_run[c] = 0;
          end
        end else if (m_level[c] && m_long[c]) begin
          if (repeat_en[c]) begin
            m_run[c]++;
            if (m_run[c] % REP == 0) push_ev(c, 4);
          end else begin
            m_run[c] = 0;
          end
        end
      end
    end
  end

  function automatic logic pulse_of(int k, int c);
    case (k)
      0: return press_pulse[c];
      1: return release_pulse[c];
      2: return click_pulse[c];
      3: return long_pulse[c];
      default: return repeat_pulse[c];
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < N; c++) begin
      checks++;
      if (level[c] !== m_level[c]) begin
        errors++;
        $display("FAIL level ch%0d cyc %0d: got %b expected %b", c, cyc, level[c], m_level[c]);
      end
      for (int k = 0; k < 5; k++) begin
        if (pulse_of(k, c) === 1'b1) begin
          if (seen_cnt[c][k] == 0) seen_first[c][k] = cyc;
          seen_cnt[c][k]++;
          seen_last[c][k] = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse ch%0d kind %0d cyc %0d: got pulse expected none", c, k, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ch != c || e.kind != k) begin
              errors++;
              $display("FAIL pulse_order cyc %0d: got ch%0d kind %0d expected ch%0d kind %0d at cyc %0d",
                       cyc, c, k, e.ch, e.kind, e.cyc);
            end
          end
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse ch%0d kind %0d: got none expected pulse at cyc %0d",
               exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_seen();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 5; k++) begin
        seen_cnt[c][k] = 0; seen_first[c][k] = -1; seen_last[c][k] = -1;
      end
  endtask

  function automatic int all_outs();
    return int'({level, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse});
  endfunction

  initial begin
    int t0;
    int ch;
    clr_seen();
    #2 reset = 1'b0;
    tick(3);
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    tick(5);

    // glitch shorter than the debounce window
    clr_seen();
    btn[0] = 1'b1; tick(3); btn[0] = 1'b0; tick(15);
    chk("glitch_press_cnt", seen_cnt[0][0], 0);
    chk("glitch_outputs", all_outs(), 0);

    // short press
    clr_seen();
    btn[0] = 1'b1; t0 = cyc; tick(12); btn[0] = 1'b0; tick(15);
    chk("short_press_at", seen_first[0][0] - t0, 6);
    chk("short_release_at", seen_first[0][1] - t0, 18);
    chk("short_click_at", seen_first[0][2] - t0, 18);
    chk("short_long_cnt", seen_cnt[0][3], 0);

    // long press with repeat enabled
    clr_seen();
    repeat_en[1] = 1'b1; btn[1] = 1'b1; t0 = cyc; tick(50); btn[1] = 1'b0; tick(15);
    chk("long_press_at", seen_first[1][0] - t0, 6);
    chk("long_long_at", seen_first[1][3] - t0, 26);
    chk("long_first_repeat_at", seen_first[1][4] - t0, 31);
    chk("long_release_at", seen_first[1][1] - t0, 56);
    chk("long_click_cnt", seen_cnt[1][2], 0);

    // long press with repeat disabled
    clr_seen();
    repeat_en[1] = 1'b0; btn[1] = 1'b1; t0 = cyc; tick(50); btn[1] = 1'b0; tick(15);
    chk("norep_long_at", seen_first[1][3] - t0, 26);
    chk("norep_repeat_cnt", seen_cnt[1][4], 0);

    // bouncy release
    btn[2] = 1'b1; tick(20);
    clr_seen();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      btn[2] = ~btn[2]; t0 = cyc; tick(2);
    end
    tick(20);
    chk("bouncy_release_cnt", seen_cnt[2][1], 1);
    chk("bouncy_release_at", seen_first[2][1] - t0, 6);
    chk("bouncy_press_cnt", seen_cnt[2][0], 0);

    // independence
    clr_seen();
    btn = 3'b111; t0 = cyc; tick(12); btn[0] = 1'b0; tick(30);
    chk("indep_ch0_press_at", seen_first[0][0] - t0, 6);
    chk("indep_ch0_click_at", seen_first[0][2] - t0, 18);
    chk("indep_ch1_long_at", seen_first[1][3] - t0, 26);
    chk("indep_ch2_long_at", seen_first[2][3] - t0, 26);
    chk("indep_ch12_release_cnt", seen_cnt[1][1] + seen_cnt[2][1], 0);
    btn = '0; tick(15);

    // reset mid-hold
    clr_seen();
    btn[0] = 1'b1; t0 = cyc; tick(16);
    reset = 1'b0;
    #1 chk("midreset_outputs", all_outs(), 0);
    tick(3);
    clr_seen();
    reset = 1'b1; t0 = cyc; tick(40);
    chk("midreset_press_at", seen_first[0][0] - t0, 6);
    chk("midreset_long_at", seen_first[0][3] - t0, 26);
    btn[0] = 1'b0; tick(15);

    // randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      ch = int'($urandom_range(0, N - 1));
      btn[ch] = ~btn[ch];
      if ($urandom_range(0, 3) == 0) repeat_en = N'($urandom);
      if (it == 150) begin
        reset = 1'b0;
        #1 chk("rand_reset_outputs", all_outs(), 0);
        tick(2);
        reset = 1'b1;
      end
      tick(int'($urandom_range(1, 35)));
    end
    btn = '0; tick(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
